// File: rtl/binary_capture_printer.sv
// Keyboard binary-entry capture: gathers NUM_BITS '0'/'1' keys into a value
// and echoes it over the uart tx handshake in binary or hex, then CR LF.
module binary_capture_printer #(
  parameter int NUM_BITS = 8,
  parameter bit REVERSE  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                new_rx_data,
  input  logic                fmt,
  output logic [7:0]          tx_data,
  output logic                new_tx_data,
  input  logic                tx_busy,
  output logic [NUM_BITS-1:0] value,
  output logic                value_valid
);

  localparam int HD = (NUM_BITS + 3) / 4;
  localparam int CW = $clog2(NUM_BITS + 1);
  localparam int IW = $clog2(NUM_BITS + 3);

  typedef enum logic [1:0] {
    COLLECT,
    SEND,
    GAP
  } state_e;

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [NUM_BITS-1:0]   shift_q;
  logic [NUM_BITS-1:0]   value_q;
  logic                  vv_q;
  logic                  fmt_q;
  logic                  ntx_q;
  logic [7:0]            txd_q;
  logic [IW-1:0]         idx_q;

  logic                  is_bit;
  logic                  is_esc;
  logic                  done;
  logic [NUM_BITS-1:0]   shift_d;
  logic [NUM_BITS-1:0]   mask;
  logic [HD*4-1:0]       pad;
  logic [3:0]            nib;
  logic                  bitv;
  logic [7:0]            chr_d;
  logic                  last;
  int                    ii;
  int                    ndig;

  assign is_bit = (rx_data == 8'h30) || (rx_data == 8'h31);
  assign is_esc = (rx_data == 8'h1B);
  assign done   = (cnt_q == CW'(NUM_BITS));
  assign mask   = NUM_BITS'(1'b1) << cnt_q;
  assign pad    = (HD*4)'(value_q);

  always_comb begin
    shift_d = shift_q;
    if (REVERSE) begin
      if (rx_data[0]) shift_d = shift_q | mask;
      else            shift_d = shift_q & ~mask;
    end else begin
      shift_d = (shift_q << 1) | NUM_BITS'(rx_data[0]);
    end
  end

  // Character for the current message index, derived from the held value.
  always_comb begin
    ii    = int'(idx_q);
    ndig  = fmt_q ? HD : NUM_BITS;
    nib   = 4'(pad >> (4 * (HD - 1 - ii)));
    bitv  = 1'(value_q >> (NUM_BITS - 1 - ii));
    chr_d = 8'h0A;
    if (ii < ndig) begin
      if (fmt_q) begin
        if (nib < 4'd10) chr_d = 8'h30 + {4'h0, nib};
        else             chr_d = 8'h37 + {4'h0, nib};
      end else begin
        chr_d = {7'b0011000, bitv};
      end
    end else if (ii == ndig) begin
      chr_d = 8'h0D;
    end
    last = (ii == ndig + 1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      shift_q <= '0;
      value_q <= '0;
      vv_q    <= 1'b0;
      fmt_q   <= 1'b0;
      ntx_q   <= 1'b0;
      txd_q   <= 8'h00;
      idx_q   <= '0;
    end else begin
      vv_q  <= 1'b0;
      ntx_q <= 1'b0;
      unique case (state_q)
        COLLECT: begin
          if (done) begin
            value_q <= shift_q;
            vv_q    <= 1'b1;
            fmt_q   <= fmt;
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= SEND;
          end else if (new_rx_data) begin
            if (is_bit) begin
              shift_q <= shift_d;
              cnt_q   <= cnt_q + CW'(1);
            end else if (is_esc) begin
              shift_q <= '0;
              cnt_q   <= '0;
            end
          end
        end
        SEND: begin
          if (!tx_busy) begin
            txd_q   <= chr_d;
            ntx_q   <= 1'b1;
            state_q <= GAP;
          end
        end
        GAP: begin
          idx_q   <= idx_q + IW'(1);
          state_q <= last ? COLLECT : SEND;
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign tx_data     = txd_q;
  assign new_tx_data = ntx_q;
  assign value       = value_q;
  assign value_valid = vv_q;

endmodule

// File: tb/tb_binary_capture_printer.sv
// Directed bench: three configurations (8/MSB-first, 8/LSB-first, 10 bits)
// driven by a vector table plus busy, drop and reset sequences.
module tb_binary_capture_printer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] rx_data;
  logic       new_rx;
  logic       fmt;
  int         sel;

  logic [7:0]  txd   [3];
  logic        ntx   [3];
  logic        tbusy [3];
  logic        vv    [3];
  logic        nrx   [3];
  logic [63:0] val   [3];
  logic [7:0]  va, vb;
  logic [9:0]  vc;

  assign nrx[0] = new_rx && (sel == 0);
  assign nrx[1] = new_rx && (sel == 1);
  assign nrx[2] = new_rx && (sel == 2);
  assign val[0] = 64'(va);
  assign val[1] = 64'(vb);
  assign val[2] = 64'(vc);

  binary_capture_printer #(.NUM_BITS(8), .REVERSE(1'b0)) u_a (
    .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(nrx[0]),
    .fmt(fmt), .tx_data(txd[0]), .new_tx_data(ntx[0]),
    .tx_busy(tbusy[0]), .value(va), .value_valid(vv[0]));

  binary_capture_printer #(.NUM_BITS(8), .REVERSE(1'b1)) u_b (
    .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(nrx[1]),
    .fmt(fmt), .tx_data(txd[1]), .new_tx_data(ntx[1]),
    .tx_busy(tbusy[1]), .value(vb), .value_valid(vv[1]));

  binary_capture_printer #(.NUM_BITS(10), .REVERSE(1'b0)) u_c (
    .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(nrx[2]),
    .fmt(fmt), .tx_data(txd[2]), .new_tx_data(ntx[2]),
    .tx_busy(tbusy[2]), .value(vc), .value_valid(vv[2]));

  // uart tx model: busy for busy_len cycles starting the cycle after a strobe
  int busy_len;
  int bcnt [3];
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst)        bcnt[d] <= 0;
      else if (ntx[d]) bcnt[d] <= busy_len;
      else if (bcnt[d] > 0) bcnt[d] <= bcnt[d] - 1;
    end
  end
  assign tbusy[0] = (bcnt[0] != 0);
  assign tbusy[1] = (bcnt[1] != 0);
  assign tbusy[2] = (bcnt[2] != 0);

  logic [7:0] q [$];
  int         vvc [3];
  int         proto_bad;
  logic       pntx [3];

  initial begin
    proto_bad = 0;
    for (int d = 0; d < 3; d++) begin
      vvc[d]  = 0;
      pntx[d] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (ntx[d] === 1'b1) begin
        q.push_back(txd[d]);
        if (tbusy[d] || pntx[d] || d != sel) proto_bad++;
      end
      if (vv[d] === 1'b1) vvc[d]++;
      pntx[d] = (ntx[d] === 1'b1);
    end
  end

  int total = 0;
  int bad   = 0;

  function automatic string pretty(input string s);
    string r;
    r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] >= 8'd32 && s[i] < 8'd127) r = {r, $sformatf("%c", s[i])};
      else r = {r, $sformatf("<%02h>", s[i])};
    end
    return r;
  endfunction

  function automatic string qstr(input int from);
    string r;
    r = "";
    for (int i = from; i < q.size(); i++) r = {r, $sformatf("%c", q[i])};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic chks(input string nm, input string a, input string e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", nm,
               pretty(a), pretty(e));
    end
  endtask

  task automatic send_key(input logic [7:0] c);
    @(negedge clk);
    rx_data = c;
    new_rx  = 1'b1;
    @(negedge clk);
    new_rx  = 1'b0;
  endtask

  task automatic wait_chars(input int n, input string nm);
    for (int k = 0; k < 6000 && q.size() < n; k++) @(posedge clk);
    if (q.size() < n) begin
      total++;
      bad++;
      $display("FAIL %s timeout: got %0d chars expected %0d",
               nm, q.size(), n);
    end
    repeat (4) @(posedge clk);
  endtask

  typedef struct {
    int          d;
    string       keys;
    bit          f;
    logic [63:0] v;
    string       tx;
  } vec_t;

  task automatic run_vec(input vec_t t, input string nm);
    int base;
    int vb0;
    sel  = t.d;
    fmt  = t.f;
    base = q.size();
    vb0  = vvc[t.d];
    for (int i = 0; i < t.keys.len(); i++) send_key(t.keys[i]);
    wait_chars(base + t.tx.len(), nm);
    chk({nm, "_value"}, val[t.d], t.v);
    chk({nm, "_vvalid"}, 64'(vvc[t.d] - vb0), 64'd1);
    chks({nm, "_tx"}, qstr(base), t.tx);
  endtask

  vec_t vt [8];

  initial begin
    int base;
    int vb0;
    int n0;
    rst      = 1'b0;
    rx_data  = 8'h00;
    new_rx   = 1'b0;
    fmt      = 1'b0;
    sel      = 0;
    busy_len = 2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_value%0d", d), val[d], 64'd0);
      chk($sformatf("reset_ntx%0d", d), 64'(ntx[d]), 64'd0);
      chk($sformatf("reset_txd%0d", d), 64'(txd[d]), 64'd0);
      chk($sformatf("reset_vv%0d", d), 64'(vv[d]), 64'd0);
    end
    rst = 1'b1;

    vt[0] = '{0, "10110010", 1'b0, 64'hB2, "10110010\015\012"};
    vt[1] = '{0, "10110010", 1'b1, 64'hB2, "B2\015\012"};
    vt[2] = '{1, "10110010", 1'b1, 64'h4D, "4D\015\012"};
    vt[3] = '{0, "1x0 1\03300000001", 1'b1, 64'h01, "01\015\012"};
    vt[4] = '{2, "1111111111", 1'b1, 64'h3FF, "3FF\015\012"};
    vt[5] = '{2, "0000000001", 1'b0, 64'h001, "0000000001\015\012"};
    vt[6] = '{1, "10000000", 1'b0, 64'h01, "00000001\015\012"};
    vt[7] = '{2, "1010101010", 1'b1, 64'h2AA, "2AA\015\012"};
    for (int i = 0; i < 8; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // long busy, keys during completion cycle and during the print
    busy_len = 20;
    sel  = 0;
    fmt  = 1'b0;
    base = q.size();
    vb0  = vvc[0];
    for (int i = 0; i < 8; i++) send_key((i % 4) < 2 ? 8'h31 : 8'h30);
    rx_data = 8'h31;
    new_rx  = 1'b1;
    @(negedge clk);
    new_rx  = 1'b0;
    repeat (12) begin
      repeat (5) @(negedge clk);
      send_key(8'h31);
    end
    wait_chars(base + 10, "t5");
    chks("t5_tx", qstr(base), "11001100\015\012");
    chk("t5_value", val[0], 64'hCC);
    chk("t5_vvalid", 64'(vvc[0] - vb0), 64'd1);
    run_vec('{0, "00000011", 1'b1, 64'h03, "03\015\012"}, "t5_next");
    busy_len = 2;

    // reset in the middle of a message
    sel  = 0;
    fmt  = 1'b0;
    base = q.size();
    for (int i = 0; i < 8; i++) send_key((i % 2) == 0 ? 8'h31 : 8'h30);
    for (int k = 0; k < 2000 && q.size() < base + 3; k++) @(posedge clk);
    chk("t6_third_char", 64'(q.size() - base), 64'd3);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_ntx", 64'(ntx[0]), 64'd0);
    chk("t6_value", val[0], 64'd0);
    chk("t6_txd", 64'(txd[0]), 64'd0);
    rst = 1'b1;
    n0  = q.size();
    repeat (60) @(negedge clk);
    chk("t6_no_tx", 64'(q.size()), 64'(n0));
    run_vec('{0, "01010101", 1'b0, 64'h55, "01010101\015\012"}, "t6_fresh");

    chk("protocol", 64'(proto_bad), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
